// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: steps I/K through the 64 rounds and owns the H0..H7 chaining state.
// Optional SHA224_EN adds MODE_224 to select the SHA-224 IV on a first block.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         FIRST_BLK,
`ifdef SHA224_EN
  input  logic         MODE_224,
`endif
  input  logic         W_VALID,
  input  logic [255:0] WORK_IN,
  output logic         LOAD,
  output logic         STEP,
  output logic [5:0]   I,
  output logic [31:0]  K,
  output logic [255:0] H_OUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [5:0]   LAST  = 6'(ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ADD, S_FIN} state_t;

  state_t        state_q;
  logic [5:0]    idx_q;
  logic          load_q, busy_q, done_q;
  logic [255:0]  h_q, h_d, iv_d;

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    k = 32'h0;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Lane-wise feed-forward; carries never cross a 32-bit word boundary.
  always_comb begin
    h_d = '0;
    for (int n = 0; n < 8; n++) begin
      h_d[n*32 +: 32] = h_q[n*32 +: 32] + WORK_IN[n*32 +: 32];
    end
  end

  always_comb begin
`ifdef SHA224_EN
    iv_d = MODE_224 ? IV224 : IV256;
`else
    iv_d = IV256;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_q     <= IV256;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q <= S_LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= 6'd0;
            if (FIRST_BLK) h_q <= iv_d;
          end
        end
        S_LOAD: state_q <= S_RUN;
        S_RUN: begin
          if (W_VALID) begin
            if (idx_q == LAST) begin
              idx_q   <= 6'd0;
              state_q <= S_ADD;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        S_ADD: begin
          h_q     <= h_d;
          done_q  <= 1'b1;
          state_q <= S_FIN;
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign STEP  = (state_q == S_RUN) && W_VALID;
  assign LOAD  = load_q;
  assign DONE  = done_q;
  assign BUSY  = busy_q;
  assign I     = idx_q;
  assign K     = k_rom(idx_q);
  assign H_OUT = h_q;

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencer for the SHA-256 compression datapath: runs the 64 round steps for one message block and supplies the round index and K constant each step. Owns the 8x32 chaining hash state: loads the IV for a first block and performs the final H += working-variable addition. Sits between the message/padding front end and the round datapath with its W schedule memory.

Parameters:
ROUNDS, 64, round steps per block; must be 64 for SHA-2; exposed only for short-run debug benches.

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  asynchronous, active-high reset.
START  in  1  begin compressing one block; sampled only in IDLE.
FIRST_BLK  in  1  sampled with START; 1 = init H from IV, 0 = chain from current H.
W_VALID  in  1  W word for the current ROUND is available from the schedule memory.
WORK_IN  in  256  datapath a..h after the last round; a in [255:224] through h in [31:0].
LOAD  out  1  one-cycle strobe: datapath loads a..h from H_OUT.
STEP  out  1  datapath performs one round this cycle.
I  out  6  current round index 0..63.
K  out  32  K constant for index I.
H_OUT  out  256  chaining/digest state; H0 in [255:224] through H7 in [31:0].
BUSY  out  1  high from START acceptance until DONE.
DONE  out  1  one-cycle pulse when H_OUT holds the updated digest.

Behaviour:
- FSM states: IDLE, LOAD, RUN, ADD, FIN.
- Reset (async, any state): state=IDLE, I=0, BUSY=0, DONE=0, LOAD=0, STEP=0, H_OUT=SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). Any block in progress is abandoned; nothing partial is written to H_OUT.
- IDLE:
  - START=1 -> LOAD and BUSY=1.
  - If FIRST_BLK=1, H_OUT <= IV on the same edge.
- LOAD:
  - LOAD=1 and I=0 for exactly one cycle.
  - Datapath captures H_OUT on this edge.
  - Then -> RUN.
- RUN:
  - STEP = W_VALID (combinational); STEP is low when W_VALID is low, and I holds.
  - On each edge with STEP=1 and I<ROUNDS-1: I <= I+1.
  - On the edge with STEP=1 and I==ROUNDS-1: I <= 0 and -> ADD.
- ADD:
  - One cycle. Each 32-bit lane Hn <= Hn + WORK_IN lane n, mod 2^32, no carry between lanes.
  - Then -> FIN.
- FIN:
  - DONE=1 for one cycle, BUSY=0 on exit, -> IDLE.
  - H_OUT holds until the next ADD, FIRST_BLK start or reset.
- K is combinational from I via a 64-entry ROM (FIPS 180-4). Valid in every state.
- START in any state other than IDLE is ignored; no queuing.
- FIRST_BLK is ignored except on the START acceptance edge.
- With W_VALID held high, the START-accept edge to the DONE-high cycle is 67 cycles: 1 LOAD + 64 RUN + 1 ADD + 1 FIN entry.
- LOAD, STEP and DONE are mutually exclusive.

Optional Feature:
SHA224_EN:
- Defined: adds input MODE_224 (1 bit), sampled with START when FIRST_BLK=1.
  - MODE_224=1 loads the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - MODE_224=0 loads the SHA-256 IV.
  - Reset value stays the SHA-256 IV.
- Undefined: port absent; the SHA-256 IV is always used.

Test Plan:
- Reset: assert RESET mid-RUN at I=30 -> BUSY=0, I=0, H_OUT=SHA-256 IV immediately, without waiting for a clock edge; next START runs normally.
- Single block "abc" (FIRST_BLK=1, W_VALID=1, bench round model) -> DONE 67 cycles after START; H_OUT=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (FIRST_BLK=1 then 0) -> H_OUT=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- W_VALID dropped for 5 cycles at I=10 and for 1 cycle at I=63 -> I holds and STEP=0 during each gap; DONE arrives at cycle 73; digest unchanged versus the no-stall run.
- START pulsed during RUN and FIN, FIRST_BLK toggled mid-block -> ignored; single DONE; correct digest. K checks: K=428a2f98 at I=0, K=c67178f2 at I=63.
- SHA224_EN defined, MODE_224=1, "abc" -> H_OUT[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
